mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 17, byte address width.
REQ-002 SHALL have parameter LEN, default 32, data word width.
REQ-003 SHALL have parameter BURST_MAX, default 8, maximum beats per burst (power of two).
REQ-004 SHALL have parameter INDEX_SIZE, default 3, log2(BURST_MAX).
REQ-005 SHALL have parameter FAIR_LIMIT, default 4, consecutive data grants before a forced instruction grant.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst  in  1  reset, asynchronous and active-high.
REQ-008 i_vis_signal  in  2  instruction cache request: MEM_NOP / MEM_READ / MEM_READ_BURST.
REQ-009 i_addr  in  ADDR_WIDTH  instruction request base address.
REQ-010 d_vis_signal  in  2  data cache request: MEM_NOP / MEM_READ / MEM_READ_BURST / MEM_WRITE.
REQ-011 d_addr  in  ADDR_WIDTH  data request base address.
REQ-012 d_length  in  INDEX_SIZE  data burst beat count; 0 means BURST_MAX.
REQ-013 d_writen_data  in  LEN  single-word write data.
REQ-014 mem_status  out  2  MEM_RESTING / MEM_INST_WORKING / MEM_DATA_WORKING, broadcast to both caches.
REQ-015 mem_data  out  LEN  registered read data, shared by both caches.
REQ-016 i_done, d_done  out  1 each  one-cycle pulse per completed beat of the owning requester.
REQ-017 i_last, d_last  out  1 each  high together with the final done pulse of a transaction.
REQ-018 ram_en, ram_we  out  1 each  RAM access strobe and write enable.
REQ-019 ram_addr  out  ADDR_WIDTH;  ram_wdata  out  LEN;  ram_rdata  in  LEN, valid the cycle after ram_en sampled.

Function
REQ-020 States SHALL be IDLE, INST, DATA; mem_status SHALL be RESTING / INST_WORKING / DATA_WORKING respectively.
REQ-021 Request = vis_signal != MEM_NOP, sampled only in IDLE; requesters hold the request until granted.
REQ-022 Both requesting in IDLE SHALL grant DATA (data has priority).
REQ-023 Grant at edge E0: latch base address, beat count (instruction burst = BURST_MAX, single = 1), op; drive ram_en, ram_addr = base from E0.
REQ-024 Burst SHALL issue one beat per cycle, beat k at address base + 4k, ADDR_WIDTH wrap-around without error.
REQ-025 Read beat issued after edge E SHALL capture ram_rdata into mem_data at E+2 with done pulsed for the cycle after E+2; beats complete in issue order.
REQ-026 MEM_WRITE SHALL be single-beat: ram_we=1, ram_wdata=d_writen_data latched at grant; d_done and d_last pulse after E+1.
REQ-027 ram_en SHALL deassert after last beat issued; state SHALL return to IDLE on the edge that raises the last done; IDLE SHALL last at least one cycle.
REQ-028 Requests, address or length changes while INST/DATA SHALL be ignored.
REQ-029 MEM_WRITE or unknown code on i_vis_signal SHALL be treated as MEM_NOP.
REQ-030 done/last SHALL only pulse for the current owner; never both requesters in one cycle.

Reset
REQ-031 rst SHALL immediately force IDLE, mem_status=MEM_RESTING, mem_data=0, all done/last=0, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, fairness counter=0.
REQ-032 Reset mid-transaction SHALL abort it; no done pulse for in-flight beats after rst deasserts.

Configuration
REQ-033 Macro ARB_FAIRNESS_EN: when defined, counter increments on each DATA grant while i request pending, clears on INST grant; at FAIR_LIMIT a simultaneous request SHALL grant INST.
REQ-034 Without ARB_FAIRNESS_EN: strict data priority, no counter logic.

Verification
REQ-035 Reset -> mem_status=RESTING, all outputs 0; rst asserted mid-burst beat 3 -> IDLE immediately, no further i_done.
REQ-036 d MEM_READ addr 0x100, RAM[0x100]=0xDEADBEEF -> ram_en one cycle, mem_data=0xDEADBEEF with d_done=d_last=1 two cycles after grant, back to IDLE.
REQ-037 i MEM_READ_BURST addr 0x1FFFC -> 8 beats at 0x1FFFC,0x00000,...,0x00018 wrapping; 8 i_done pulses, i_last on 8th.
REQ-038 Simultaneous i MEM_READ and d MEM_WRITE 0x40 data 0x12345678 -> DATA first, RAM[0x40]=0x12345678, then INST granted after one RESTING cycle.
REQ-039 d MEM_READ_BURST d_length=0 -> 8 beats; d_length=3 -> 3 beats, d_last on 3rd.
REQ-040 ARB_FAIRNESS_EN, both hold requests continuously -> grant order D,D,D,D,I,D...; without macro -> D only while d holds.

Source files
------------

// File: rtl/mem_arbiter.sv
// Instruction/data cache arbiter in front of one single-port RAM with registered read data.
// Define ARB_FAIRNESS_EN to force an instruction grant after FAIR_LIMIT data grants that starved it.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 17,
    parameter int LEN        = 32,
    parameter int BURST_MAX  = 8,
    parameter int INDEX_SIZE = 3,
    parameter int FAIR_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            i_vis_signal,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [1:0]            d_vis_signal,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [INDEX_SIZE-1:0] d_length,
    input  logic [LEN-1:0]        d_writen_data,
    output logic [1:0]            mem_status,
    output logic [LEN-1:0]        mem_data,
    output logic                  i_done,
    output logic                  d_done,
    output logic                  i_last,
    output logic                  d_last,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [LEN-1:0]        ram_wdata,
    input  logic [LEN-1:0]        ram_rdata
);
    localparam logic [1:0] MEM_NOP        = 2'd0;
    localparam logic [1:0] MEM_READ       = 2'd1;
    localparam logic [1:0] MEM_READ_BURST = 2'd2;
    localparam logic [1:0] MEM_WRITE      = 2'd3;
    localparam int         CW             = INDEX_SIZE + 1;

    // State encoding doubles as mem_status (RESTING / INST_WORKING / DATA_WORKING).
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INST = 2'd1,
        DATA = 2'd2
    } state_t;

    if (BURST_MAX != (1 << INDEX_SIZE) || FAIR_LIMIT < 1) begin : g_cfg_check
        $error("mem_arbiter: BURST_MAX must equal 2**INDEX_SIZE and FAIR_LIMIT must be at least 1");
    end

    state_t                state_q;
    logic [LEN-1:0]        mem_data_q;
    logic                  i_done_q, d_done_q, i_last_q, d_last_q;
    logic                  ram_en_q, ram_we_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [LEN-1:0]        ram_wdata_q;
    logic [CW-1:0]         beats_q;
    logic                  rd_pend_q, rd_last_q;

`ifdef ARB_FAIRNESS_EN
    localparam int FW = $clog2(FAIR_LIMIT + 1);
    logic [FW-1:0] fair_q;
`endif

    logic          i_req, d_req, grant_inst, grant_data;
    logic [CW-1:0] i_beats, d_beats;

    always_comb begin
        i_req = (i_vis_signal == MEM_READ) || (i_vis_signal == MEM_READ_BURST);
        d_req = d_vis_signal != MEM_NOP;
`ifdef ARB_FAIRNESS_EN
        grant_inst = i_req && (!d_req || fair_q == FW'(FAIR_LIMIT));
`else
        grant_inst = i_req && !d_req;
`endif
        grant_data = d_req && !grant_inst;
        i_beats    = (i_vis_signal == MEM_READ_BURST) ? CW'(BURST_MAX) : CW'(1);
        d_beats    = CW'(1);
        if (d_vis_signal == MEM_READ_BURST) begin
            d_beats = (d_length == '0) ? CW'(BURST_MAX) : {1'b0, d_length};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_data_q  <= '0;
            i_done_q    <= 1'b0;
            d_done_q    <= 1'b0;
            i_last_q    <= 1'b0;
            d_last_q    <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            beats_q     <= '0;
            rd_pend_q   <= 1'b0;
            rd_last_q   <= 1'b0;
`ifdef ARB_FAIRNESS_EN
            fair_q      <= '0;
`endif
        end else begin
            // NOTE: done/last default low each cycle so they are single-cycle pulses.
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_last_q  <= 1'b0;
            d_last_q  <= 1'b0;
            rd_pend_q <= ram_en_q && !ram_we_q;
            rd_last_q <= ram_en_q && !ram_we_q && (beats_q == CW'(1));
            case (state_q)
                IDLE: begin
                    if (grant_inst || grant_data) begin
                        state_q    <= grant_inst ? INST : DATA;
                        ram_en_q   <= 1'b1;
                        ram_we_q   <= grant_data && (d_vis_signal == MEM_WRITE);
                        ram_addr_q <= grant_inst ? i_addr : d_addr;
                        beats_q    <= grant_inst ? i_beats : d_beats;
                        if (grant_data && d_vis_signal == MEM_WRITE) begin
                            ram_wdata_q <= d_writen_data;
                        end
`ifdef ARB_FAIRNESS_EN
                        if (grant_inst) begin
                            fair_q <= '0;
                        end else if (i_req) begin
                            fair_q <= fair_q + FW'(1);
                        end
`endif
                    end
                end
                default: begin
                    if (ram_en_q) begin
                        if (beats_q == CW'(1)) begin
                            ram_en_q <= 1'b0;
                            ram_we_q <= 1'b0;
                        end else begin
                            ram_addr_q <= ram_addr_q + ADDR_WIDTH'(4);
                        end
                        beats_q <= beats_q - CW'(1);
                    end
                    if (ram_en_q && ram_we_q) begin
                        d_done_q <= 1'b1;
                        d_last_q <= 1'b1;
                        state_q  <= IDLE;
                    end
                    // Read data lands one cycle after the RAM sampled the strobe.
                    if (rd_pend_q) begin
                        mem_data_q <= ram_rdata;
                        i_done_q   <= state_q == INST;
                        d_done_q   <= state_q == DATA;
                        i_last_q   <= (state_q == INST) && rd_last_q;
                        d_last_q   <= (state_q == DATA) && rd_last_q;
                        if (rd_last_q) begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign mem_status = state_q;
    assign mem_data   = mem_data_q;
    assign i_done     = i_done_q;
    assign d_done     = d_done_q;
    assign i_last     = i_last_q;
    assign d_last     = d_last_q;
    assign ram_en     = ram_en_q;
    assign ram_we     = ram_we_q;
    assign ram_addr   = ram_addr_q;
    assign ram_wdata  = ram_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table, hand-timed corner cases and a done/RAM scoreboard.
// Builds with or without ARB_FAIRNESS_EN; the fairness grant order adapts to the macro.
`timescale 1ns/1ps
module tb_mem_arbiter;
    localparam int         AW  = 17;
    localparam int         DW  = 32;
    localparam logic [1:0] NOP = 2'd0;
    localparam logic [1:0] RD  = 2'd1;
    localparam logic [1:0] RDB = 2'd2;
    localparam logic [1:0] WR  = 2'd3;

    logic          clk = 1'b0;
    logic          rst;
    logic [1:0]    i_vis_signal, d_vis_signal;
    logic [AW-1:0] i_addr, d_addr;
    logic [2:0]    d_length;
    logic [DW-1:0] d_writen_data;
    logic [1:0]    mem_status;
    logic [DW-1:0] mem_data;
    logic          i_done, d_done, i_last, d_last;
    logic          ram_en, ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    mem_arbiter #(.ADDR_WIDTH(AW), .LEN(DW), .BURST_MAX(8), .INDEX_SIZE(3), .FAIR_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .i_vis_signal(i_vis_signal), .i_addr(i_addr),
        .d_vis_signal(d_vis_signal), .d_addr(d_addr), .d_length(d_length),
        .d_writen_data(d_writen_data),
        .mem_status(mem_status), .mem_data(mem_data),
        .i_done(i_done), .d_done(d_done), .i_last(i_last), .d_last(d_last),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic          we;
        logic [DW-1:0] wdata;
    } ram_exp_t;

    typedef struct {
        logic          is_d;
        logic [DW-1:0] data;
        logic          last;
        logic          is_write;
    } done_exp_t;

    typedef struct {
        string         name;
        logic          is_d;
        logic [1:0]    op;
        logic [AW-1:0] addr;
        logic [2:0]    len;
        logic [DW-1:0] wdata;
        int            beats;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;
    int i_done_cnt = 0, d_done_cnt = 0, i_last_cnt = 0, d_last_cnt = 0;

    ram_exp_t  ram_q[$];
    done_exp_t sb_q[$];
    ram_exp_t  re;
    done_exp_t de;

    logic [DW-1:0] ram_wr [int unsigned];
    logic [DW-1:0] shadow [int unsigned];

    function automatic logic [DW-1:0] pat(input int unsigned w);
        if (w == 32'h40) return 32'hDEADBEEF;
        return (w * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    function automatic logic [DW-1:0] exp_word(input int unsigned w);
        return shadow.exists(w) ? shadow[w] : pat(w);
    endfunction

    function automatic logic [DW-1:0] ram_peek(input int unsigned w);
        return ram_wr.exists(w) ? ram_wr[w] : pat(w);
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // RAM model: read data valid the cycle after the strobe is sampled.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram_wr[32'(ram_addr[AW-1:2])] = ram_wdata;
            else        ram_rdata <= ram_peek(32'(ram_addr[AW-1:2]));
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (ram_en) begin
                if (ram_q.size() == 0) begin
                    check("ram_en_unexpected", ram_en, 1'b0);
                end else begin
                    re = ram_q.pop_front();
                    check("ram_addr", ram_addr, re.addr);
                    check("ram_we", ram_we, re.we);
                    if (re.we) check("ram_wdata", ram_wdata, re.wdata);
                end
            end
            if (i_done || d_done) begin
                if (i_done) i_done_cnt++;
                if (d_done) d_done_cnt++;
                if (i_last) i_last_cnt++;
                if (d_last) d_last_cnt++;
                check("done_exclusive", i_done & d_done, 1'b0);
                if (sb_q.size() == 0) begin
                    check("done_unexpected", i_done | d_done, 1'b0);
                end else begin
                    de = sb_q.pop_front();
                    check("done_owner", d_done, de.is_d);
                    check("done_last", de.is_d ? d_last : i_last, de.last);
                    if (!de.is_write) check("mem_data", mem_data, de.data);
                end
            end
            if ((i_last && !i_done) || (d_last && !d_done)) begin
                check("last_without_done", i_last | d_last, 1'b0);
            end
        end
    end

    task automatic push_exp(input logic is_d, input logic [1:0] op, input logic [AW-1:0] addr,
                            input logic [2:0] len, input logic [DW-1:0] wdata);
        int            n;
        logic [AW-1:0] a;
        int unsigned   w;
        if (!is_d && !(op == RD || op == RDB)) return;
        if (is_d && op == NOP) return;
        n = (op == RDB) ? ((is_d && len != 3'd0) ? int'(len) : 8) : 1;
        for (int k = 0; k < n; k++) begin
            a = addr + AW'(4 * k);
            w = 32'(a[AW-1:2]);
            ram_q.push_back('{a, op == WR, wdata});
            sb_q.push_back('{is_d, exp_word(w), k == n - 1, op == WR});
            if (op == WR) shadow[w] = wdata;
        end
    endtask

    task automatic drive(input logic is_d, input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [2:0] len, input logic [DW-1:0] wdata);
        if (is_d) begin
            d_vis_signal = op; d_addr = addr; d_length = len; d_writen_data = wdata;
        end else begin
            i_vis_signal = op; i_addr = addr;
        end
    endtask

    task automatic flush_on_timeout();
        ram_q.delete();
        sb_q.delete();
    endtask

    task automatic wait_grant(output logic [1:0] st);
        st = 2'd0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk); #1;
            if (mem_status != 2'd0) begin
                st = mem_status;
                break;
            end
        end
        if (st == 2'd0) begin
            check("grant_timeout", mem_status != 2'd0, 1'b1);
            flush_on_timeout();
        end
    endtask

    task automatic wait_idle();
        bit seen = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (mem_status == 2'd0) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            check("idle_timeout", mem_status, 2'd0);
            flush_on_timeout();
        end
    endtask

    task automatic run_vec(input vec_t v);
        int         i0, d0, il0, dl0;
        logic [1:0] st;
        i0 = i_done_cnt; d0 = d_done_cnt; il0 = i_last_cnt; dl0 = d_last_cnt;
        push_exp(v.is_d, v.op, v.addr, v.len, v.wdata);
        drive(v.is_d, v.op, v.addr, v.len, v.wdata);
        if (v.beats == 0) begin
            repeat (6) @(posedge clk);
            #1;
            check({v.name, "_ignored"}, mem_status, 2'd0);
            drive(v.is_d, NOP, '0, '0, '0);
            return;
        end
        wait_grant(st);
        check({v.name, "_owner"}, st, v.is_d ? 2'd2 : 2'd1);
        drive(v.is_d, NOP, '0, '0, '0);
        wait_idle();
        @(negedge clk); #1;
        check({v.name, "_beats"}, v.is_d ? d_done_cnt - d0 : i_done_cnt - i0, v.beats);
        check({v.name, "_lasts"}, v.is_d ? d_last_cnt - dl0 : i_last_cnt - il0, 1);
        check({v.name, "_other_quiet"}, v.is_d ? i_done_cnt - i0 : d_done_cnt - d0, 0);
    endtask

    initial begin
        #100us;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    initial begin
        vec_t       vecs[9];
        logic [1:0] st;
        logic [1:0] got[6];
        logic [1:0] exp_order[6];
        int         n_idle, ng, i0;
        logic [1:0] prev;

        vecs[0] = '{"d_read_single",  1'b1, RD,  17'h00204, 3'd0, 32'h0,        1};
        vecs[1] = '{"i_burst_wrap",   1'b0, RDB, 17'h1FFFC, 3'd0, 32'h0,        8};
        vecs[2] = '{"d_burst_len0",   1'b1, RDB, 17'h00200, 3'd0, 32'h0,        8};
        vecs[3] = '{"d_burst_len3",   1'b1, RDB, 17'h00300, 3'd3, 32'h0,        3};
        vecs[4] = '{"i_read_single",  1'b0, RD,  17'h00000, 3'd0, 32'h0,        1};
        vecs[5] = '{"d_write",        1'b1, WR,  17'h00080, 3'd0, 32'hCAFEF00D, 1};
        vecs[6] = '{"d_read_back",    1'b1, RD,  17'h00080, 3'd0, 32'h0,        1};
        vecs[7] = '{"i_write_nop",    1'b0, WR,  17'h00040, 3'd0, 32'h0,        0};
        vecs[8] = '{"d_burst_wrap",   1'b1, RDB, 17'h1FFF8, 3'd5, 32'h0,        5};

        rst = 1'b1;
        i_vis_signal = NOP; i_addr = '0;
        d_vis_signal = NOP; d_addr = '0; d_length = '0; d_writen_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_status", mem_status, 2'd0);
        check("rst_mem_data", mem_data, '0);
        check("rst_done_last", {i_done, d_done, i_last, d_last}, 4'b0);
        check("rst_ram_ctl", {ram_en, ram_we}, 2'b0);
        check("rst_ram_addr", ram_addr, '0);
        check("rst_ram_wdata", ram_wdata, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single data read: exact cycle timing from the grant edge.
        push_exp(1'b1, RD, 17'h00100, 3'd0, '0);
        drive(1'b1, RD, 17'h00100, 3'd0, '0);
        wait_grant(st);
        check("rd100_owner", st, 2'd2);
        check("rd100_en_e0", ram_en, 1'b1);
        check("rd100_addr_e0", ram_addr, 17'h00100);
        drive(1'b1, NOP, '0, '0, '0);
        @(posedge clk); #1;
        check("rd100_en_e1", ram_en, 1'b0);
        check("rd100_done_e1", d_done, 1'b0);
        @(posedge clk); #1;
        check("rd100_done_e2", {d_done, d_last}, 2'b11);
        check("rd100_data_e2", mem_data, 32'hDEADBEEF);
        check("rd100_idle_e2", mem_status, 2'd0);
        @(posedge clk); #1;
        check("rd100_done_pulse", d_done, 1'b0);

        for (int v = 0; v < 9; v++) run_vec(vecs[v]);

        // Simultaneous instruction read and data write: data first, one idle cycle, then instruction.
        push_exp(1'b1, WR, 17'h00040, 3'd0, 32'h12345678);
        push_exp(1'b0, RD, 17'h00010, 3'd0, '0);
        drive(1'b1, WR, 17'h00040, 3'd0, 32'h12345678);
        drive(1'b0, RD, 17'h00010, 3'd0, '0);
        wait_grant(st);
        check("sim_first_data", st, 2'd2);
        drive(1'b1, NOP, '0, '0, '0);
        wait_idle();
        n_idle = 0;
        while (mem_status == 2'd0 && n_idle < 10) begin
            n_idle++;
            @(posedge clk); #1;
        end
        check("sim_idle_gap", n_idle, 1);
        check("sim_then_inst", mem_status, 2'd1);
        drive(1'b0, NOP, '0, '0, '0);
        wait_idle();
        @(negedge clk); #1;
        check("sim_ram_written", ram_peek(32'h10), 32'h12345678);

        // Both requesters hold single reads continuously.
`ifdef ARB_FAIRNESS_EN
        exp_order = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd1, 2'd2};
`else
        exp_order = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2};
`endif
        for (int k = 0; k < 6; k++) begin
            push_exp(exp_order[k] == 2'd2, RD, (exp_order[k] == 2'd2) ? 17'h00104 : 17'h00008, 3'd0, '0);
            got[k] = 2'd0;
        end
        drive(1'b1, RD, 17'h00104, 3'd0, '0);
        drive(1'b0, RD, 17'h00008, 3'd0, '0);
        ng = 0;
        prev = 2'd0;
        for (int c = 0; c < 80 && ng < 6; c++) begin
            @(posedge clk); #1;
            if (prev == 2'd0 && mem_status != 2'd0) begin
                got[ng] = mem_status;
                ng++;
            end
            prev = mem_status;
        end
        drive(1'b1, NOP, '0, '0, '0);
        drive(1'b0, NOP, '0, '0, '0);
        wait_idle();
        @(negedge clk); #1;
        for (int k = 0; k < 6; k++) check($sformatf("fair_grant_%0d", k), got[k], exp_order[k]);
        if (ng < 6) flush_on_timeout();

        // Reset while the third beat of an instruction burst is on the RAM port.
        push_exp(1'b0, RDB, 17'h00400, 3'd0, '0);
        drive(1'b0, RDB, 17'h00400, 3'd0, '0);
        wait_grant(st);
        drive(1'b0, NOP, '0, '0, '0);
        repeat (2) @(posedge clk);
        #2;
        check("mid_beat3_addr", ram_addr, 17'h00408);
        check("mid_beat1_done", i_done, 1'b1);
        rst = 1'b1;
        #1;
        ram_q.delete();
        sb_q.delete();
        check("mid_rst_status", mem_status, 2'd0);
        check("mid_rst_ram_en", ram_en, 1'b0);
        check("mid_rst_done", {i_done, i_last}, 2'b0);
        check("mid_rst_addr", ram_addr, '0);
        check("mid_rst_data", mem_data, '0);
        i0 = i_done_cnt;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (12) @(posedge clk);
        #1;
        check("post_rst_no_i_done", i_done_cnt - i0, 0);
        check("post_rst_idle", mem_status, 2'd0);
        check("sb_drained", ram_q.size() + sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
